// File: rtl/apb_pkg.sv
// Shared FSM state type and APB width limits for the arbitrated APB master.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_AW_MAX = 32;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr_i and wraps.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(ptr_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Arbitrated APB master: round-robin selects one of NREQ requesters and runs
// a single APB transfer at a time, with an ACCESS-phase timeout.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                            pclk,
    input  logic                            preset,
    input  logic [NREQ-1:0]                 i_req,
    input  logic [NREQ-1:0]                 i_wr,
    input  logic [NREQ*AW-1:0]              i_addr,
    input  logic [NREQ*DW-1:0]              i_wdata,
    input  logic [NREQ*strb_width(DW)-1:0]  i_strb,
    output logic [NREQ-1:0]                 o_gnt,
    output logic [NREQ-1:0]                 o_done,
    output logic [DW-1:0]                   o_rdata,
    output logic                            o_err,
    output logic [AW-1:0]                   o_paddr,
    output logic                            o_pwrite,
    output logic                            o_psel,
    output logic                            o_penable,
    output logic [DW-1:0]                   o_pwdata,
    output logic [strb_width(DW)-1:0]       o_pstrb,
    input  logic [DW-1:0]                   i_prdata,
    input  logic                            i_pslverr,
    input  logic                            i_pready
);

    localparam int SW = strb_width(DW);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    if (AW < 1 || AW > APB_AW_MAX) begin : g_bad_aw
        $error("apb_arb_master: AW out of range");
    end

    apb_state_e      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, win_idx;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] win_oh, owner_oh;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d, pwdata_q, pwdata_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [SW-1:0]   pstrb_q, pstrb_d;
    logic            err_q, err_d, pwrite_q, pwrite_d;
    logic            psel_q, psel_d, penable_q, penable_d;
    logic            timed_out;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .gnt_o (win_oh)
    );

    always_comb begin
        win_idx = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (win_oh[r]) win_idx = PW'(r);
        end
    end

    assign owner_oh  = NREQ'(1) << owner_q;
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    ptr_d     = win_idx;
                    owner_d   = win_idx;
                    gnt_d     = win_oh;
                    cnt_d     = '0;
                    paddr_d   = i_addr[win_idx*AW +: AW];
                    pwrite_d  = i_wr[win_idx];
                    // Reads drive zero data/strobe on the bus.
                    pwdata_d  = i_wr[win_idx] ? i_wdata[win_idx*DW +: DW] : '0;
                    pstrb_d   = i_wr[win_idx] ? i_strb[win_idx*SW +: SW] : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready on the last allowed cycle wins over the timeout.
                if (i_pready || timed_out) begin
                    done_d    = owner_oh;
                    err_d     = i_pready ? i_pslverr : 1'b1;
                    rdata_d   = (i_pready && !pwrite_q) ? i_prdata : '0;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= PW'(NREQ - 1);
            owner_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_done    = done_q;
    assign o_rdata   = rdata_q;
    assign o_err     = err_q;
    assign o_paddr   = paddr_q;
    assign o_pwrite  = pwrite_q;
    assign o_pwdata  = pwdata_q;
    assign o_pstrb   = pstrb_q;
    assign o_psel    = psel_q;
    assign o_penable = penable_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: directed vectors, corner sequences and random
// traffic against a transaction-level reference model and APB completer.
module tb_apb_arb_master;

    localparam int DW      = 32;
    localparam int AW      = 5;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam logic [4:0] ERR_ADDR = 5'h0C;

    logic        pclk   = 1'b0;
    logic        preset = 1'b1;
    logic [1:0]  i_req  = '0;
    logic [1:0]  i_wr   = '0;
    logic [9:0]  i_addr = '0;
    logic [63:0] i_wdata = '0;
    logic [7:0]  i_strb = '0;
    logic [1:0]  o_gnt, o_done;
    logic [31:0] o_rdata, o_pwdata, i_prdata;
    logic        o_err, o_pwrite, o_psel, o_penable, i_pslverr, i_pready;
    logic [4:0]  o_paddr;
    logic [3:0]  o_pstrb;

    apb_arb_master #(.DW(DW), .AW(AW), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset),
        .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata), .i_strb(i_strb),
        .o_gnt(o_gnt), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
        .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel), .o_penable(o_penable),
        .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
        .i_prdata(i_prdata), .i_pslverr(i_pslverr), .i_pready(i_pready)
    );

    always #5 pclk = ~pclk;

    // APB completer: ready after cur_wait wait states; 0x0C is read-only.
    logic [31:0] slv_mem [32] = '{default: '0};
    int acc_n    = 0;
    int cur_wait = 0;

    assign i_pready  = o_psel && o_penable && (acc_n >= cur_wait);
    assign i_prdata  = (o_paddr == ERR_ADDR) ? 32'hDEAD_BEEF : slv_mem[o_paddr];
    assign i_pslverr = o_pwrite && (o_paddr == ERR_ADDR);

    always @(posedge pclk) begin
        if (o_psel && o_penable && !i_pready) acc_n <= acc_n + 1;
        else acc_n <= 0;
        if (o_psel && o_penable && i_pready && o_pwrite && o_paddr != ERR_ADDR)
            for (int b = 0; b < 4; b++)
                if (o_pstrb[b]) slv_mem[o_paddr][b*8 +: 8] <= o_pwdata[b*8 +: 8];
    end

    // Transaction-level reference model.
    int          n_tests = 0, n_fail = 0, cyc = 0, next_wait = 0;
    bit          m_busy = 0, m_wr = 0, m_err = 0;
    int          m_owner = 0, m_last = NREQ - 1, m_gnt_cyc = 0, m_done_at = 0, m_wait = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_strb = '0;
    logic [31:0] ref_mem [32] = '{default: '0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        m_busy  = 0;
        m_last  = NREQ - 1;
        m_rdata = '0;
        m_err   = 0;
    endtask

    task automatic set_txn(input int r, input bit wr, input logic [4:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        i_wr[r]              = wr;
        i_addr[r*AW +: AW]   = addr;
        i_wdata[r*DW +: DW]  = wdata;
        i_strb[r*4 +: 4]     = strb;
    endtask

    // One clock; compare every output against the model; requesters drop on done.
    task automatic step();
        logic [1:0] exp_gnt, exp_done;
        int w, best_d, d;
        @(posedge pclk);
        #1;
        cyc++;
        exp_gnt  = '0;
        exp_done = '0;
        if (m_busy) begin
            if (cyc == m_done_at) begin
                exp_done[m_owner] = 1'b1;
                if (m_wait > TIMEOUT - 1) begin
                    m_err = 1; m_rdata = '0;
                end else if (m_wr) begin
                    m_rdata = '0;
                    m_err   = (m_addr == ERR_ADDR);
                    if (!m_err)
                        for (int b = 0; b < 4; b++)
                            if (m_strb[b]) ref_mem[m_addr][b*8 +: 8] = m_wdata[b*8 +: 8];
                end else begin
                    m_err   = 0;
                    m_rdata = (m_addr == ERR_ADDR) ? 32'hDEAD_BEEF : ref_mem[m_addr];
                end
                m_busy = 0;
            end
        end else if (i_req != 0) begin
            w = 0; best_d = NREQ;
            for (int r = 0; r < NREQ; r++)
                if (i_req[r]) begin
                    d = (r - m_last - 1 + 2 * NREQ) % NREQ;
                    if (d < best_d) begin best_d = d; w = r; end
                end
            exp_gnt[w] = 1'b1;
            m_busy = 1; m_owner = w; m_last = w; m_gnt_cyc = cyc;
            m_wr = i_wr[w]; m_addr = i_addr[w*AW +: AW];
            m_wdata = i_wdata[w*DW +: DW]; m_strb = i_strb[w*4 +: 4];
            m_wait = next_wait; cur_wait = next_wait;
            m_done_at = cyc + 2 + ((m_wait < TIMEOUT - 1) ? m_wait : TIMEOUT - 1);
        end
        chk("gnt", o_gnt, exp_gnt);
        chk("done", o_done, exp_done);
        chk("psel", o_psel, m_busy);
        chk("penable", o_penable, m_busy && cyc > m_gnt_cyc);
        chk("rdata", o_rdata, m_rdata);
        chk("err", o_err, m_err);
        if (m_busy) begin
            chk("paddr", o_paddr, m_addr);
            chk("pwrite", o_pwrite, m_wr);
            chk("pwdata", o_pwdata, m_wr ? m_wdata : 32'h0);
            chk("pstrb", o_pstrb, m_wr ? m_strb : 4'h0);
        end
        for (int r = 0; r < NREQ; r++)
            if (o_done[r]) i_req[r] = 1'b0;
    endtask

    task automatic wait_ev(input bit want_done, output bit ok, output int n);
        ok = 0; n = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            n++;
            if (want_done ? (o_done != 0) : (o_gnt != 0)) ok = 1;
        end
    endtask

    typedef struct packed {
        int          r;
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit ok;
        int n, gc, n_gnt, idle_cnt, a, sel;
        int rem [2];
        int order_log [4];
        int exp_order [4];
        logic [4:0] addr;

        vecs[0] = '{0, 1'b1, 5'h08, 32'hA5A5_0001, 0,  32'h0,         1'b0, 2};
        vecs[1] = '{0, 1'b0, 5'h08, 32'h0,         0,  32'hA5A5_0001, 1'b0, 2};
        vecs[2] = '{1, 1'b0, 5'h0C, 32'h0,         2,  32'hDEAD_BEEF, 1'b0, 4};
        vecs[3] = '{0, 1'b1, 5'h0C, 32'h1111_2222, 0,  32'h0,         1'b1, 2};
        vecs[4] = '{1, 1'b0, 5'h08, 32'h0,         15, 32'hA5A5_0001, 1'b0, 17};
        vecs[5] = '{0, 1'b0, 5'h08, 32'h0,         16, 32'h0,         1'b1, 17};
        vecs[6] = '{1, 1'b1, 5'h10, 32'h1234_5678, 1,  32'h0,         1'b0, 3};
        vecs[7] = '{0, 1'b0, 5'h10, 32'h0,         0,  32'h1234_5678, 1'b0, 2};
        exp_order = '{0, 1, 0, 1};

        // Reset values.
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_gnt", o_gnt, 0);       chk("rst_done", o_done, 0);
        chk("rst_rdata", o_rdata, 0);   chk("rst_err", o_err, 0);
        chk("rst_paddr", o_paddr, 0);   chk("rst_pwrite", o_pwrite, 0);
        chk("rst_psel", o_psel, 0);     chk("rst_penable", o_penable, 0);
        chk("rst_pwdata", o_pwdata, 0); chk("rst_pstrb", o_pstrb, 0);
        preset = 1'b0;
        reset_model();

        // Two requesters held for four transfers: strict alternation from req0.
        set_txn(0, 1'b1, 5'h01, 32'h0000_00A0, 4'hF);
        set_txn(1, 1'b0, 5'h02, 32'h0, 4'h0);
        next_wait = 0;
        i_req = 2'b11;
        rem = '{2, 2};
        n_gnt = 0; idle_cnt = 0;
        order_log = '{-1, -1, -1, -1};
        for (int i = 0; i < 60 && (rem[0] + rem[1]) > 0; i++) begin
            step();
            if (o_gnt != 0 && n_gnt < 4) begin
                order_log[n_gnt] = o_gnt[1] ? 1 : 0;
                n_gnt++;
            end
            for (int r = 0; r < 2; r++)
                if (o_done[r]) begin
                    rem[r]--;
                    if (rem[r] > 0) i_req[r] = 1'b1;
                end
            if ((rem[0] + rem[1]) > 0 && n_gnt > 0 && !o_psel) idle_cnt++;
        end
        chk("rr_all_done", rem[0] + rem[1], 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order_log[i], exp_order[i]);
        chk("rr_idle_cycles", idle_cnt, 3);
        step();

        // Directed single transfers, including the timeout boundary.
        for (int i = 0; i < 8; i++) begin
            set_txn(vecs[i].r, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF);
            next_wait = vecs[i].wait_n;
            i_req[vecs[i].r] = 1'b1;
            wait_ev(0, ok, n);
            chk($sformatf("vec%0d_gnt_seen", i), ok, 1);
            chk($sformatf("vec%0d_gnt", i), o_gnt, 2'b01 << vecs[i].r);
            gc = cyc;
            wait_ev(1, ok, n);
            chk($sformatf("vec%0d_done_seen", i), ok, 1);
            chk($sformatf("vec%0d_done", i), o_done, 2'b01 << vecs[i].r);
            chk($sformatf("vec%0d_rdata", i), o_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), o_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_latency", i), cyc - gc, vecs[i].exp_lat);
            step();
        end

        // Reset during ACCESS, then the pending req1 wins right after release.
        set_txn(0, 1'b0, 5'h08, 32'h0, 4'h0);
        next_wait = 100;
        i_req[0] = 1'b1;
        wait_ev(0, ok, n);
        chk("mid_rst_gnt0", o_gnt, 2'b01);
        set_txn(1, 1'b0, 5'h10, 32'h0, 4'h0);
        i_req[1] = 1'b1;
        step();
        step();
        preset = 1'b1;
        #1;
        chk("mid_rst_psel", o_psel, 0);
        chk("mid_rst_penable", o_penable, 0);
        chk("mid_rst_done", o_done, 0);
        i_req[0] = 1'b0;
        next_wait = 0;
        repeat (2) begin
            @(posedge pclk);
            #1;
            chk("mid_rst_hold_done", o_done, 0);
            chk("mid_rst_hold_psel", o_psel, 0);
        end
        preset = 1'b0;
        reset_model();
        wait_ev(0, ok, n);
        chk("post_rst_gnt", o_gnt, 2'b10);
        chk("post_rst_gnt_delay", n, 1);
        wait_ev(1, ok, n);
        chk("post_rst_done", o_done, 2'b10);
        chk("post_rst_rdata", o_rdata, 32'h1234_5678);
        step();

        // Random traffic with random wait states around the timeout boundary.
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < NREQ; r++)
                if (!i_req[r] && $urandom_range(0, 3) == 0) begin
                    a = $urandom_range(0, 8);
                    addr = (a == 8) ? ERR_ADDR : 5'(a);
                    set_txn(r, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(1, 15)));
                    i_req[r] = 1'b1;
                end
            sel = $urandom_range(0, 9);
            next_wait = (sel < 7) ? $urandom_range(0, 3) :
                        (sel == 7) ? $urandom_range(14, 17) : $urandom_range(4, 10);
            step();
            // Owner may withdraw its request mid-transfer; the transfer must still finish.
            for (int r = 0; r < NREQ; r++)
                if (o_gnt[r] && $urandom_range(0, 7) == 0) i_req[r] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1);
    end

endmodule
